// File: rtl/bgd_prod_accumulate.sv
// Dot-product back end for the BGD multiplier lanes: it tracks lane validity, reduces each beat
// with an adder tree, and accumulates the beats of a vector into a saturated result behind a valid/ready handshake.

module bgd_prod_lane #(
  parameter int DIN_WIDTH = 13,
  parameter int TW        = 16
) (
  input  logic [DIN_WIDTH-1:0] p,
  output logic [TW-1:0]        x
);
  assign x = {{(TW-DIN_WIDTH){p[DIN_WIDTH-1]}}, p};
endmodule

module bgd_prod_accumulate #(
  parameter int LANES       = 8,
  parameter int DIN_WIDTH   = 13,
  parameter int ACC_WIDTH   = 24,
  parameter int MUL_LATENCY = 3,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din_valid,
  input  logic [LANES*DIN_WIDTH-1:0] prod,
  input  logic [LEN_WIDTH-1:0]       vec_len,
  output logic                       mul_ce,
  output logic [ACC_WIDTH-1:0]       sum_data,
  output logic                       sum_ovf,
  output logic                       sum_valid,
  input  logic                       sum_ready
);
  // Tree width grows by log2(LANES), so the per-beat reduction can never overflow.
  localparam int TW = DIN_WIDTH + $clog2(LANES);

  logic [MUL_LATENCY-1:0]     vld_pipe;
  logic                       pv, tv, ovf, sat, last;
  logic [LANES-1:0][TW-1:0]   lane_x;
  logic signed [TW-1:0]       tree_sum, tsum;
  logic signed [ACC_WIDTH-1:0] acc, sat_val;
  logic signed [ACC_WIDTH:0]  nxt;
  logic [LEN_WIDTH-1:0]       cnt, len_q, len_new, len_cur;

  assign mul_ce = !(sum_valid && !sum_ready);
  assign pv     = vld_pipe[MUL_LATENCY-1];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bgd_prod_lane #(.DIN_WIDTH(DIN_WIDTH), .TW(TW)) u_lane (
      .p (prod[g*DIN_WIDTH +: DIN_WIDTH]),
      .x (lane_x[g])
    );
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) tree_sum = tree_sum + $signed(lane_x[i]);
  end

  always_comb begin
    nxt     = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH+1-TW){tsum[TW-1]}}, tsum};
    sat     = nxt[ACC_WIDTH] != nxt[ACC_WIDTH-1];
    sat_val = nxt[ACC_WIDTH-1:0];
    if (sat) sat_val = nxt[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  // On the first beat the length comes straight from vec_len; afterwards from the latched copy.
  always_comb begin
    len_new = (vec_len == '0) ? LEN_WIDTH'(1) : vec_len;
    len_cur = (cnt == '0) ? len_new : len_q;
    last    = (cnt == len_cur - LEN_WIDTH'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      tv        <= 1'b0;
      tsum      <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      len_q     <= '0;
      sum_data  <= '0;
      sum_ovf   <= 1'b0;
      sum_valid <= 1'b0;
    end else if (mul_ce) begin
      vld_pipe[0] <= din_valid;
      for (int i = 1; i < MUL_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      tv <= pv;
      if (pv) tsum <= tree_sum;
      if (tv) begin
        if (cnt == '0) len_q <= len_new;
        if (last) begin
          sum_data  <= sat_val;
          sum_ovf   <= ovf | sat;
          sum_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= sat_val;
          cnt <= cnt + LEN_WIDTH'(1);
          ovf <= ovf | sat;
        end
      end
      // With mul_ce high a pending result is being taken, so drop valid unless a new one lands.
      if (!(tv && last) && sum_valid && sum_ready) sum_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bgd_prod_accumulate.sv
// Scoreboard bench: a 24-bit and a 16-bit accumulator see the same stream, and the expected results come from a wide-integer model.
module tb_bgd_prod_accumulate;
  localparam int LANES = 8, DW = 13, ML = 3, LW = 8;

  logic clk = 1'b0, reset = 1'b1, din_valid = 1'b0, sum_ready = 1'b0;
  logic [LW-1:0] vec_len = 8'd1;
  logic [LANES-1:0][DW-1:0] ops = '0;
  logic [LANES-1:0][DW-1:0] ops_q [ML];
  logic [LANES*DW-1:0] prod;
  logic mul_ce, sum_ovf, sum_valid, mul_ce16, sum_ovf16, sum_valid16;
  logic [23:0] sum_data;
  logic [15:0] sum_data16;

  bgd_prod_accumulate #(.ACC_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .prod(prod), .vec_len(vec_len),
    .mul_ce(mul_ce), .sum_data(sum_data), .sum_ovf(sum_ovf), .sum_valid(sum_valid),
    .sum_ready(sum_ready));

  bgd_prod_accumulate #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .prod(prod), .vec_len(vec_len),
    .mul_ce(mul_ce16), .sum_data(sum_data16), .sum_ovf(sum_ovf16), .sum_valid(sum_valid16),
    .sum_ready(sum_ready));

  always #5 clk = ~clk;

  // The multipliers modelled as a plain delay stalled by mul_ce.
  always @(posedge clk) if (mul_ce) begin
    ops_q[0] <= ops;
    for (int i = 1; i < ML; i++) ops_q[i] <= ops_q[i-1];
  end
  assign prod = ops_q[ML-1];

  typedef struct { longint d24; bit o24; longint d16; bit o16; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, stall_cyc = 0;
  longint m_a24 = 0, m_a16 = 0;
  bit m_o24 = 0, m_o16 = 0;
  int m_cnt = 0, m_len = 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint hi = (longint'(1) <<< (w-1)) - 1;
    longint lo = -(longint'(1) <<< (w-1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic model_flush();
    m_cnt = 0; m_a24 = 0; m_a16 = 0; m_o24 = 0; m_o16 = 0;
  endtask

  task automatic model_beat(input logic [LANES-1:0][DW-1:0] v);
    longint bs = 0, n24, n16, s24, s16;
    for (int i = 0; i < LANES; i++) bs += longint'($signed(v[i]));
    if (m_cnt == 0) m_len = (vec_len == 0) ? 1 : int'(vec_len);
    n24 = m_a24 + bs; n16 = m_a16 + bs;
    s24 = sat(n24, 24); s16 = sat(n16, 16);
    if (m_cnt == m_len - 1) begin
      sb.push_back('{d24: s24, o24: m_o24 | (s24 != n24), d16: s16, o16: m_o16 | (s16 != n16)});
      model_flush();
    end else begin
      m_a24 = s24; m_a16 = s16;
      m_o24 |= (s24 != n24); m_o16 |= (s16 != n16);
      m_cnt++;
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (!mul_ce) stall_cyc++;
    if (sum_valid && sum_ready) begin
      if (sb.size() == 0) chk("unexp_result", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("data24", longint'($signed(sum_data)), mon_e.d24);
        chk("ovf24", longint'(sum_ovf), longint'(mon_e.o24));
        chk("data16", longint'($signed(sum_data16)), mon_e.d16);
        chk("ovf16", longint'(sum_ovf16), longint'(mon_e.o16));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat has been taken.
  task automatic issue(input logic [LANES-1:0][DW-1:0] v);
    bit ok = 0;
    ops = v; din_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); ok = mul_ce;
      @(posedge clk); #1;
      if (ok) break;
    end
    din_valid = 1'b0;
    if (ok) model_beat(v); else chk("issue_timeout", 0, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    sum_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) cycles(1);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    cycles(8);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); n++;
      if (sum_valid) break;
    end
    chk(tag, longint'(sum_valid), 1);
  endtask

  function automatic logic [LANES-1:0][DW-1:0] ramp(input int base, input int step);
    logic [LANES-1:0][DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i] = DW'(base + step * i);
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog sim did not finish");
    $fatal(1);
  end

  initial begin
    logic [LANES-1:0][DW-1:0] v;
    int n, s0;
    cycles(3);
    chk("rst_valid", longint'(sum_valid), 0);
    chk("rst_data", longint'(sum_data), 0);
    chk("rst_mul_ce", longint'(mul_ce), 1);
    reset = 1'b0;
    cycles(2);

    // single beat, latency 5
    sum_ready = 1'b1; vec_len = 8'd1;
    issue(ramp(1, 1));
    wait_valid("single_valid", n);
    chk("single_latency", n + 1, 5 + 1);
    cycles(1);
    drain();

    // multi-beat with negatives, then vec_len=0
    vec_len = 8'd3;
    v = '0; for (int i = 0; i < 5; i++) v[i] = 13'd20;
    issue(v);
    issue(ramp(-4096, 0));
    v = '0; v[0] = 13'd50;
    issue(v);
    drain();
    vec_len = 8'd0;
    issue(ramp(1, 1));
    issue(ramp(-3, 1));
    drain();

    // saturation of the 16-bit accumulator
    vec_len = 8'd2;
    issue(ramp(4095, 0));
    issue(ramp(4095, 0));
    drain();
    vec_len = 8'd1;
    issue(ramp(1, 0));
    drain();

    // backpressure: four stalled cycles with the first result held
    sum_ready = 1'b0; vec_len = 8'd1;
    s0 = stall_cyc;
    issue(ramp(1, 1));
    issue(ramp(-1, 0));
    wait_valid("bp_valid", n);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      chk("bp_mul_ce", longint'(mul_ce), 0);
      chk("bp_hold", longint'($signed(sum_data)), 36);
    end
    @(posedge clk); #1;
    sum_ready = 1'b1;
    drain();
    chk("bp_stall_cycles", stall_cyc - s0, 4);

    // back-to-back results with ready tied high
    sum_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          for (int l = 0; l < LANES; l++) v[l] = DW'($urandom_range(0, 8191));
          issue(v);
        end
      end
      begin
        int m;
        wait_valid("b2b_first", m);
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk("b2b_valid", longint'(sum_valid), 1);
          chk("b2b_mul_ce", longint'(mul_ce), 1);
        end
      end
    join
    cycles(1);
    drain();

    // reset with a result held, then mid-vector
    sum_ready = 1'b0; vec_len = 8'd1;
    issue(ramp(1, 1));
    wait_valid("rst2_pre_valid", n);
    #2 reset = 1'b1;
    #1;
    chk("rst2_valid", longint'(sum_valid), 0);
    chk("rst2_data", longint'(sum_data), 0);
    chk("rst2_ovf", longint'(sum_ovf), 0);
    chk("rst2_mul_ce", longint'(mul_ce), 1);
    sb.delete(); model_flush();
    @(posedge clk); #1;
    reset = 1'b0; sum_ready = 1'b1; vec_len = 8'd3;
    issue(ramp(4000, 0));
    issue(ramp(4000, 0));
    cycles(2);
    #3 reset = 1'b1;
    sb.delete(); model_flush();
    @(posedge clk); #1;
    reset = 1'b0; vec_len = 8'd1;
    cycles(1);
    issue(ramp(1, 1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bgd_prod_accumulate.md
# bgd_prod_accumulate

Downstream consumer of the eight parallel 13-bit signed multiplier lanes in the BGD datapath. It receives the lane products and tracks their validity through the multiplier pipeline. It reduces the eight products per beat with an adder tree and accumulates the beats of one vector into a saturated dot-product result. The result is offered to the sigmoid/update stage through a valid/ready handshake. On backpressure it freezes the multiplier pipeline through `mul_ce`.

## Interface
- `LANES`, 8, number of parallel multiplier lanes
- `DIN_WIDTH`, 13, signed product width per lane
- `ACC_WIDTH`, 24, signed accumulator and result width (≥ DIN_WIDTH+3)
- `MUL_LATENCY`, 3, enabled cycles from operand issue to product on `prod`
- `LEN_WIDTH`, 8, width of vector length

- `clk` in 1: clock, all registers on rising edge
- `reset` in 1: asynchronous, active-high
- `din_valid` in 1: operands issued to the multipliers this cycle; only counts when `mul_ce`=1
- `prod` in LANES*DIN_WIDTH: packed lane products; lane i at bits [i*DIN_WIDTH +: DIN_WIDTH]
- `vec_len` in LEN_WIDTH: beats per vector; must be held stable for the whole vector; 0 is treated as 1
- `mul_ce` out 1: clock enable for the multipliers and the operand issue logic
- `sum_data` out ACC_WIDTH: signed dot-product result
- `sum_ovf` out 1: the result saturated during this vector
- `sum_valid` out 1: result available
- `sum_ready` in 1: consumer accepts the result

## Operation
- `mul_ce` = !(sum_valid && !sum_ready). This is combinational. When it is 0, every internal register holds its value: the valid delay line, the tree register, the beat counter, the accumulator and the overflow flag.
- Valid delay line: a MUL_LATENCY-deep shift register of `din_valid`. It advances only when `mul_ce`=1. Its tap is `pv`, and `prod` is valid exactly when `pv`=1.
- Tree stage: when `mul_ce`=1 and `pv`=1, the signed sum of all LANES products is registered into `tsum`. `tsum` is DIN_WIDTH+3 bits and sign-extended, so the tree stage is exact with no overflow. The `tv` flag is also set. When `mul_ce`=1 and `pv`=0, `tv` is cleared.
- Accumulate stage: when `mul_ce`=1 and `tv`=1:
  - `nxt` = acc + sext(`tsum`), computed at ACC_WIDTH+1 bits.
  - `nxt` saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Saturation sets the internal sticky `ovf`.
- Beat counter `cnt`:
  - `cnt`=0 marks the first beat of a vector. `len_q` = max(`vec_len`,1) is latched on that beat.
  - The beat is the last beat when `cnt` = `len_q`-1. With `cnt`=0 this comparison uses the freshly computed max(`vec_len`,1).
  - Non-last beat: `acc` ← sat(`nxt`) and `cnt` increments.
  - Last beat: `sum_data` ← sat(`nxt`), `sum_ovf` ← `ovf` OR the saturation on this beat, and `sum_valid` ← 1. At the same time `acc`, `cnt` and `ovf` clear to 0.
- Handshake:
  - A transfer occurs when `sum_valid` && `sum_ready`.
  - After a transfer with no new last beat, `sum_valid` ← 0.
  - If a transfer and a new last beat coincide, the new result loads and `sum_valid` stays 1. This gives back-to-back results with no bubble.
  - `sum_data` and `sum_ovf` hold while `sum_valid`=1 and `sum_ready`=0.
- Reset: this is the defined behaviour for reset at any time, including mid-vector.
  - `sum_valid`, `sum_data` and `sum_ovf` go to 0; `mul_ce` = 1.
  - The delay line, `tv`, `tsum`, `acc`, `cnt`, `ovf` and `len_q` all clear to 0.
  - In-flight beats and partial sums are discarded.

## Timing
- Latency: the last beat is issued in cycle t, and `mul_ce`=1 from t onward.
  - `prod` is valid in cycle t+MUL_LATENCY.
  - `tsum` is valid in t+MUL_LATENCY+1.
  - `sum_valid` rises in t+MUL_LATENCY+2, which is t+5 at defaults.
- Every `mul_ce`=0 cycle adds exactly one cycle of latency.
- Throughput is one beat per cycle.
- Vectors may be issued back-to-back with no gap. The first beat of vector n+1 may directly follow the last beat of vector n.
- `mul_ce` falls in the same cycle that `sum_valid`=1 and `sum_ready`=0. It rises in the same cycle that `sum_ready` returns to 1.

## Test plan
- Reset: assert `reset` mid-stream at an arbitrary phase. Required: `sum_valid`=0, `sum_data`=0, `sum_ovf`=0 and `mul_ce`=1 immediately, with no clock edge needed. After release, a `vec_len`=1 vector gives a correct sum with no residue from before the reset.
- Single beat: `vec_len`=1, with lane products 1,2,…,8 issued in cycle t. Required: `sum_data`=36, `sum_ovf`=0, and `sum_valid`=1 in cycle t+5.
- Multi-beat with negatives: `vec_len`=3, with three consecutive beats whose lane sums are 100, -4096·8 and 50. Required: one result of -32618 after the third beat, and no intermediate `sum_valid`. Then repeat with `vec_len`=0 and check it behaves as `vec_len`=1.
- Saturation: set ACC_WIDTH=16 and `vec_len`=2, with every lane at 4095 on both beats. Required: `sum_data`=32767 and `sum_ovf`=1. The next vector, with lanes all at 1 and `vec_len`=1, gives `sum_data`=8 and `sum_ovf`=0.
- Backpressure: issue two back-to-back `vec_len`=1 vectors (sums 36 and -8), and hold `sum_ready`=0 for 4 cycles after the first `sum_valid`. Required:
  - `mul_ce`=0 for exactly those 4 cycles.
  - 36 is held stable throughout.
  - On release, 36 transfers and -8 appears, with no loss or duplication.
- Back-to-back handshake: issue continuous `vec_len`=1 vectors with `sum_ready` tied to 1. Required: `sum_valid` stays high every cycle after the first result, each result is correct, and `mul_ce` never drops.
